// File: rtl/music_sequencer_pkg.sv
// Shared encodings and constants for the music sequencer slice.
// State codes stay plain localparams so legacy tooling that decodes them keeps working.
package music_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_PLAY = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    localparam logic [19:0] REST_PERIOD = 20'd1;

    // Sheet durations are in eighth-beat units.
    localparam logic [4:0] DUR_QUARTER = 5'd2;
    localparam logic [4:0] DUR_HALF    = 5'd4;
    localparam logic [4:0] DUR_ONE     = 5'd8;
    localparam logic [4:0] DUR_TWO     = 5'd16;

    function automatic logic is_tone(input logic [19:0] period);
        return period > REST_PERIOD;
    endfunction

endpackage

// File: rtl/music_sequencer_tone_gen.sv
// Square-wave generator: toggles wave every `period` clocks while enabled.
// Periods of 0 or 1 are rests and hold the output low.
module tone_gen
    import music_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [19:0] period,
    output logic        wave
);

    logic [19:0] cnt_q, cnt_d;
    logic        wave_q, wave_d;

    always_comb begin
        cnt_d  = '0;
        wave_d = 1'b0;
        if (enable && is_tone(period)) begin
            if (cnt_q == period - 20'd1) begin
                cnt_d  = '0;
                wave_d = ~wave_q;
            end else begin
                cnt_d  = cnt_q + 20'd1;
                wave_d = wave_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            wave_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wave_q <= wave_d;
        end
    end

    assign wave = wave_q;

endmodule

// File: rtl/music_sequencer.sv
// Steps the note-sheet index, times each note's duration and trailing gap,
// and drives the speaker through tone_gen.
module music_sequencer
    import music_pkg::*;
#(
    parameter int SONG_LEN    = 11,
    parameter int TICK_CYCLES = 12500000,
    parameter int GAP_CYCLES  = 1000000,
    parameter int IDX_W       = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_en,
    output logic [IDX_W-1:0] number,
    input  logic [19:0]      note_in,
    input  logic [4:0]       duration_in,
    output logic             speaker,
    output logic             busy,
    output logic             done
);

    localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(SONG_LEN - 1);

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  number_q, number_d;
    logic [19:0]       note_q, note_d;
    logic [4:0]        dur_q, dur_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [4:0]        unit_q, unit_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              done_q, done_d;
    logic              note_end;
    logic              tone_en;

    always_comb begin
        state_d  = state_q;
        number_d = number_q;
        note_d   = note_q;
        dur_d    = dur_q;
        tick_d   = tick_q;
        unit_d   = unit_q;
        gap_d    = gap_q;
        done_d   = 1'b0;
        note_end = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    number_d = '0;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                note_d  = note_in;
                dur_d   = (duration_in == 5'd0) ? 5'd1 : duration_in;
                tick_d  = '0;
                unit_d  = '0;
                gap_d   = '0;
                state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    unit_d = unit_q + 5'd1;
                    // Compare against dur-1 so a 31-unit note never needs unit=31.
                    if (unit_q == dur_q - 5'd1) begin
                        unit_d = '0;
                        if (GAP_CYCLES == 0) begin
                            note_end = 1'b1;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d    = '0;
                    note_end = 1'b1;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (note_end) begin
            if (number_q != IDX_LAST) begin
                number_d = number_q + IDX_W'(1);
                state_d  = ST_LOAD;
            end else if (loop_en) begin
                number_d = '0;
                state_d  = ST_LOAD;
            end else begin
                number_d = '0;
                state_d  = ST_IDLE;
                done_d   = 1'b1;
            end
        end

        if (stop) begin
            state_d  = ST_IDLE;
            number_d = '0;
            done_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            number_q <= '0;
            note_q   <= '0;
            dur_q    <= '0;
            tick_q   <= '0;
            unit_q   <= '0;
            gap_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            number_q <= number_d;
            note_q   <= note_d;
            dur_q    <= dur_d;
            tick_q   <= tick_d;
            unit_q   <= unit_d;
            gap_q    <= gap_d;
            done_q   <= done_d;
        end
    end

    // Enable only while PLAY continues, so the final edge of a note (or a stop) clears the wave.
    assign tone_en = (state_q == ST_PLAY) && (state_d == ST_PLAY);

    tone_gen u_tone (
        .clk    (clk),
        .reset  (reset),
        .enable (tone_en),
        .period (note_q),
        .wave   (speaker)
    );

    assign number = number_q;
    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;

endmodule

// File: tb/tb_music_sequencer.sv
// Self-checking bench for music_sequencer with a small behavioural sheet stub
// and a note-timeline model of the expected outputs.
module tb_music_sequencer;

    localparam int SONG_LEN = 3;
    localparam int TICK     = 4;
    localparam int GAP      = 2;
    localparam int IDX_W    = 10;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             loop_en = 1'b0;
    logic [IDX_W-1:0] number;
    logic [19:0]      note_in;
    logic [4:0]       duration_in;
    logic             speaker;
    logic             busy;
    logic             done;

    int tab_note [SONG_LEN];
    int tab_dur  [SONG_LEN];

    int n_checks  = 0;
    int n_pass    = 0;
    int done_seen = 0;

    always #5 clk = ~clk;

    music_sequencer #(
        .SONG_LEN    (SONG_LEN),
        .TICK_CYCLES (TICK),
        .GAP_CYCLES  (GAP),
        .IDX_W       (IDX_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .loop_en     (loop_en),
        .number      (number),
        .note_in     (note_in),
        .duration_in (duration_in),
        .speaker     (speaker),
        .busy        (busy),
        .done        (done)
    );

    always_comb begin
        note_in     = '0;
        duration_in = '0;
        if (int'(number) < SONG_LEN) begin
            note_in     = 20'(tab_note[int'(number)]);
            duration_in = 5'(tab_dur[int'(number)]);
        end
    end

    // Model: a song is a timeline of notes; m_c is the cycle offset inside the current note
    // (0 = sheet read, then dur*TICK tone cycles, then GAP silent cycles).
    bit m_active = 1'b0;
    int m_idx    = 0;
    int m_c      = 0;
    bit m_done   = 1'b0;

    function automatic int eff_dur(input int i);
        return (tab_dur[i] == 0) ? 1 : tab_dur[i];
    endfunction

    function automatic int note_len(input int i);
        return 1 + eff_dur(i) * TICK + GAP;
    endfunction

    function automatic bit exp_speaker();
        int k;
        int n;
        if (!m_active) return 1'b0;
        k = m_c - 1;
        if (k < 0 || k >= eff_dur(m_idx) * TICK) return 1'b0;
        n = tab_note[m_idx];
        if (n < 2) return 1'b0;
        return ((k / n) % 2) == 1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active = 1'b0;
            m_idx    = 0;
            m_c      = 0;
            m_done   = 1'b0;
        end else begin
            m_done = 1'b0;
            if (stop) begin
                m_active = 1'b0;
                m_idx    = 0;
            end else if (!m_active) begin
                if (start) begin
                    m_active = 1'b1;
                    m_idx    = 0;
                    m_c      = 0;
                end
            end else begin
                m_c = m_c + 1;
                if (m_c == note_len(m_idx)) begin
                    m_c = 0;
                    if (m_idx < SONG_LEN - 1) begin
                        m_idx = m_idx + 1;
                    end else if (loop_en) begin
                        m_idx = 0;
                    end else begin
                        m_active = 1'b0;
                        m_idx    = 0;
                        m_done   = 1'b1;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        chk("number",  32'(number),  m_active ? 32'(m_idx) : 32'd0);
        chk("busy",    32'(busy),    32'(m_active));
        chk("done",    32'(done),    32'(m_done));
        chk("speaker", 32'(speaker), 32'(exp_speaker()));
        if (done === 1'b1) done_seen++;
    end

    task automatic pulse_start();
        @(negedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial begin
        int first_spk;
        int done_at;
        int done_cnt;
        int rest_hi;
        int wraps;
        int d0;
        logic [IDX_W-1:0] num12, num19, prev_num;
        logic busy25, busy26;

        tab_note = '{3, 1, 5};
        tab_dur  = '{2, 1, 0};

        repeat (3) @(negedge clk);
        chk("reset_busy",   32'(busy),    32'd0);
        chk("reset_number", 32'(number),  32'd0);
        chk("reset_spk",    32'(speaker), 32'd0);
        #1 reset = 1'b0;

        // Normal play; cycle k is the k-th cycle after the edge that samples start.
        first_spk = 0; done_at = 0; done_cnt = 0; rest_hi = 0;
        num12 = '0; num19 = '0; busy25 = 1'b0; busy26 = 1'b1;
        pulse_start();
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (speaker === 1'b1 && first_spk == 0) first_spk = k;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at == 0) done_at = k;
            end
            if (k >= 13 && k <= 16 && speaker === 1'b1) rest_hi++;
            if (k == 12) num12 = number;
            if (k == 19) num19 = number;
            if (k == 25) busy25 = busy;
            if (k == 26) busy26 = busy;
        end
        chk("pin_first_tone_edge", 32'(first_spk), 32'd5);
        chk("pin_number_note1",    32'(num12),     32'd1);
        chk("pin_number_note2",    32'(num19),     32'd2);
        chk("pin_rest_silent",     32'(rest_hi),   32'd0);
        // Edge 25 closes the last gap; done and the busy drop appear in the cycle after it.
        chk("pin_done_cycle",      32'(done_at),   32'd26);
        chk("pin_done_count",      32'(done_cnt),  32'd1);
        chk("pin_busy_last_gap",   32'(busy25),    32'd1);
        chk("pin_busy_after_done", 32'(busy26),    32'd0);

        // Looping: each pass is 25 cycles, so 60 cycles see two wraps and no done.
        #1 loop_en = 1'b1;
        d0 = done_seen;
        wraps = 0;
        prev_num = '0;
        pulse_start();
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (prev_num == 2 && number == 0 && busy === 1'b1) wraps++;
            prev_num = number;
        end
        chk("loop_wraps",   32'(wraps),            32'd2);
        chk("loop_no_done", 32'(done_seen - d0),   32'd0);
        #1 loop_en = 1'b0;
        repeat (30) @(negedge clk);
        chk("loop_final_done", 32'(done_seen - d0), 32'd1);
        chk("loop_idle",       32'(busy),           32'd0);

        // Stop during PLAY of note 0.
        d0 = done_seen;
        pulse_start();
        repeat (4) @(negedge clk);
        #1 stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        chk("stop_busy",    32'(busy),    32'd0);
        chk("stop_number",  32'(number),  32'd0);
        chk("stop_speaker", 32'(speaker), 32'd0);
        chk("stop_done",    32'(done),    32'd0);
        repeat (3) @(negedge clk);
        chk("stop_no_done", 32'(done_seen - d0), 32'd0);

        // start and stop together in IDLE.
        @(negedge clk);
        #1 begin start = 1'b1; stop = 1'b1; end
        @(posedge clk);
        #1 begin start = 1'b0; stop = 1'b0; end
        chk("startstop_idle", 32'(busy), 32'd0);

        // start while busy is ignored (the model checks every cycle).
        d0 = done_seen;
        pulse_start();
        repeat (5) @(negedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (25) @(negedge clk);
        chk("restart_ignored_done", 32'(done_seen - d0), 32'd1);

        // Async reset in the gap after note 1, with no clock edge before sampling.
        pulse_start();
        repeat (17) @(negedge clk);
        chk("pre_reset_number", 32'(number), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("areset_busy",   32'(busy),    32'd0);
        chk("areset_number", 32'(number),  32'd0);
        chk("areset_spk",    32'(speaker), 32'd0);
        chk("areset_done",   32'(done),    32'd0);
        @(negedge clk);
        #1 reset = 1'b0;
        d0 = done_seen;
        pulse_start();
        repeat (30) @(negedge clk);
        chk("replay_done", 32'(done_seen - d0), 32'd1);

        // Randomized traffic, sheet contents reshuffled only while idle.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            if (!m_active && ($urandom % 4 == 0)) begin
                for (int j = 0; j < SONG_LEN; j++) begin
                    tab_note[j] = int'($urandom_range(0, 7));
                    tab_dur[j]  = ($urandom % 8 == 0) ? 31 : int'($urandom_range(0, 3));
                end
            end
            start = ($urandom % 6 == 0);
            stop  = ($urandom % 80 == 0);
            if ($urandom % 40 == 0) loop_en = ~loop_en;
            reset = ($urandom % 400 == 0);
        end
        @(negedge clk);
        #1 begin start = 1'b0; stop = 1'b0; reset = 1'b0; end
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
